// File: rtl/isqrt_iter_responder.sv
// isqrt_iter_responder: responder end of the isqrt request/response link.
// Requests are queued in a small FIFO because the link has no ready signal.
// A shift-subtract engine then produces one root bit per cycle.
// Results leave strictly in request order, one y_vld pulse per accepted request.
// Optional build macro ISQRT_RESP_ROUND_EN: round-to-nearest result (saturating);
// when undefined the result is the exact floor root.
module isqrt_iter_responder #(
   parameter int X_W        = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               x_vld,
   input  logic [X_W-1:0]     x,
   output logic               y_vld,
   output logic [X_W/2-1:0]   y,
   output logic               busy,
   output logic               ovf
);

   localparam int Y_W   = X_W / 2;
   localparam int R_W   = Y_W + 2;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int IT_W  = $clog2(Y_W + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_DONE
   } state_t;

   state_t            state;
   logic [X_W-1:0]    mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              fifo_empty;
   logic              fifo_full;
   logic              push;
   logic              pop;
   logic              drop;
   logic [X_W-1:0]    head;

   logic [R_W-1:0]    rem;
   logic [Y_W-1:0]    root;
   logic [X_W-1:0]    xs;
   logic [IT_W-1:0]   iter;

   logic [R_W+1:0]    t;
   logic [R_W-1:0]    trial;
   logic              take;
   logic [R_W-1:0]    rem_nxt;
   logic [Y_W-1:0]    root_nxt;
   logic [Y_W-1:0]    y_nxt;

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
   assign pop        = ((state == ST_IDLE) || (state == ST_DONE)) && !fifo_empty;
   assign push       = x_vld && (!fifo_full || pop);
   assign drop       = x_vld && fifo_full && !pop;
   assign head       = mem[rd_ptr];
   assign busy       = !fifo_empty || (state != ST_IDLE);

   // FIFO storage needs no reset; only the pointers define what is valid
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= x;
      end
   end

   // FIFO pointers, occupancy and the sticky overflow flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (!push && pop) begin
            count <= count - 1'b1;
         end
         if (drop) begin
            ovf <= 1'b1;
         end
      end
   end

   // One bit-pair shift-subtract step of the root engine, plus result shaping
   always_comb begin
      t        = {rem, xs[X_W-1 -: 2]};
      trial    = {root, 2'b01};
      take     = (t >= {2'b00, trial});
      rem_nxt  = take ? R_W'(t - {2'b00, trial}) : t[R_W-1:0];
      root_nxt = Y_W'({root, take});
      y_nxt    = root_nxt;
`ifdef ISQRT_RESP_ROUND_EN
      if ((rem_nxt > {2'b00, root_nxt}) && (root_nxt != '1)) begin
         y_nxt = root_nxt + 1'b1;
      end
`endif
   end

   // Sequencer: load from FIFO, iterate Y_W steps, present result for one cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         rem   <= '0;
         root  <= '0;
         xs    <= '0;
         iter  <= '0;
         y_vld <= 1'b0;
         y     <= '0;
      end else begin
         y_vld <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (!fifo_empty) begin
                  rem   <= '0;
                  root  <= '0;
                  xs    <= head;
                  iter  <= IT_W'(Y_W - 1);
                  state <= ST_CALC;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_CALC: begin
               rem  <= rem_nxt;
               root <= root_nxt;
               xs   <= xs << 2;
               if (iter == '0) begin
                  state <= ST_DONE;
                  y_vld <= 1'b1;
                  y     <= y_nxt;
               end else begin
                  iter <= iter - 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
